// File: rtl/checkpoint_restore_ctrl.sv
// Branch checkpoint tracker: records which map-table column holds each in-flight branch's checkpoint
// and drives restore/invalidate requests when branches resolve. Define CHECKPOINT_RESTORE_CTRL_PERF_EN for perf counters.

package core_types_pkg;
    localparam int CHECKPOINT_COLUMNS = 4;
    localparam int ROB_INDEX_W        = 6;
    localparam int COLUMN_W           = $clog2(CHECKPOINT_COLUMNS);

    typedef logic [ROB_INDEX_W-1:0] ROB_index_t;
    typedef logic [COLUMN_W-1:0]    checkpoint_column_t;
endpackage

module checkpoint_restore_ctrl
    import core_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,

    input  logic               dispatch_branch_valid,
    input  ROB_index_t         dispatch_branch_ROB_index,
    output logic               dispatch_branch_ready,

    output logic               save_checkpoint_valid,
    output ROB_index_t         save_checkpoint_ROB_index,
    input  checkpoint_column_t save_checkpoint_safe_column,

    input  logic               resolve_valid,
    input  ROB_index_t         resolve_ROB_index,
    input  logic               resolve_mispredict,
    output logic               resolve_ready,

    output logic               restore_checkpoint_valid,
    output logic               restore_checkpoint_speculate_failed,
    output ROB_index_t         restore_checkpoint_ROB_index,
    output checkpoint_column_t restore_checkpoint_safe_column,
    input  logic               restore_checkpoint_success,

    output logic               restore_done_valid,
    output logic               restore_done_mispredict,
    output logic               resolve_miss,
    output logic               restore_fail,

    output logic [15:0]        mispredict_count,
    output logic [15:0]        correct_count
);

    localparam int                 COUNT_W   = $clog2(CHECKPOINT_COLUMNS + 1);
    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(CHECKPOINT_COLUMNS - 1);
    localparam logic [COUNT_W-1:0] ONE       = COUNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]                    r_state;
    logic [CHECKPOINT_COLUMNS-1:0] r_entry_valid;
    ROB_index_t                    r_entry_rob [CHECKPOINT_COLUMNS];
    logic [COUNT_W-1:0]            r_count;
    checkpoint_column_t            r_lat_column;
    ROB_index_t                    r_lat_rob;
    logic                          r_lat_mispredict;

    logic               w_idle;
    logic               w_req;
    logic               w_save;
    logic               w_resolve_accept;
    logic               w_cam_hit;
    checkpoint_column_t w_cam_column;
    checkpoint_column_t w_save_column;
    logic               w_done_mispredict;
    logic               w_done_correct;

    assign w_idle = (r_state == ST_IDLE);
    assign w_req  = (r_state == ST_REQ);

    // One column always stays free as the map table's working column.
    assign dispatch_branch_ready = w_idle & ~resolve_valid & (r_count < MAX_COUNT);
    assign resolve_ready         = w_idle;

    assign w_save                    = dispatch_branch_valid & dispatch_branch_ready;
    assign save_checkpoint_valid     = w_save;
    assign save_checkpoint_ROB_index = dispatch_branch_ROB_index;
    assign w_save_column = checkpoint_column_t'(int'(save_checkpoint_safe_column) % CHECKPOINT_COLUMNS);

    assign w_resolve_accept = resolve_valid & w_idle;

    // CAM over valid entries; lowest matching column wins if tags ever alias.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_cam_hit    = 1'b0;
        w_cam_column = '0;
        for (int i = CHECKPOINT_COLUMNS - 1; i >= 0; i--) begin
            if (r_entry_valid[i] && (r_entry_rob[i] == resolve_ROB_index)) begin
                w_cam_hit    = 1'b1;
                w_cam_column = checkpoint_column_t'(i);
            end
        end
    end

    assign resolve_miss = w_resolve_accept & ~w_cam_hit;

    assign restore_checkpoint_valid            = w_req;
    assign restore_checkpoint_speculate_failed = w_req & r_lat_mispredict;
    assign restore_checkpoint_ROB_index        = w_req ? r_lat_rob    : '0;
    assign restore_checkpoint_safe_column      = w_req ? r_lat_column : '0;

    assign w_done_mispredict       = w_req & restore_checkpoint_success & r_lat_mispredict;
    assign w_done_correct          = w_req & restore_checkpoint_success & ~r_lat_mispredict;
    assign restore_done_valid      = w_done_mispredict | w_done_correct;
    assign restore_done_mispredict = w_done_mispredict;
    assign restore_fail            = w_req & ~restore_checkpoint_success;

    // NOTE: the ROB tag array has no reset; its valid bit gates every use of a tag.
    always_ff @(posedge CLK) begin
        if (w_save) begin
            r_entry_rob[w_save_column] <= dispatch_branch_ROB_index;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state          <= ST_IDLE;
            r_entry_valid    <= '0;
            r_count          <= '0;
            r_lat_column     <= '0;
            r_lat_rob        <= '0;
            r_lat_mispredict <= 1'b0;
        end else begin
            if (w_save) begin
                r_entry_valid[w_save_column] <= 1'b1;
                r_count                      <= r_count + ONE;
            end

            if (w_resolve_accept && w_cam_hit) begin
                r_lat_column     <= w_cam_column;
                r_lat_rob        <= resolve_ROB_index;
                r_lat_mispredict <= resolve_mispredict;
                r_state          <= ST_REQ;
            end

            if (w_req) begin
                r_state <= ST_IDLE;
                if (w_done_mispredict) begin
                    // Mispredict squashes every younger branch along with this one.
                    r_entry_valid <= '0;
                    r_count       <= '0;
                end else begin
                    r_entry_valid[r_lat_column] <= 1'b0;
                    if (r_count != '0) begin
                        r_count <= r_count - ONE;
                    end
                end
            end
        end
    end

`ifdef CHECKPOINT_RESTORE_CTRL_PERF_EN
    logic [15:0] r_mispredict_count;
    logic [15:0] r_correct_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mispredict_count <= '0;
            r_correct_count    <= '0;
        end else begin
            if (w_done_mispredict && (r_mispredict_count != 16'hFFFF)) begin
                r_mispredict_count <= r_mispredict_count + 16'd1;
            end
            if (w_done_correct && (r_correct_count != 16'hFFFF)) begin
                r_correct_count <= r_correct_count + 16'd1;
            end
        end
    end

    assign mispredict_count = r_mispredict_count;
    assign correct_count    = r_correct_count;
`else
    assign mispredict_count = '0;
    assign correct_count    = '0;
`endif

endmodule
